// File: rtl/id_decode_stage_if.sv
// ID/EX pipeline-register bundle between decode and execute.
// Decode drives it through the master modport; execute reads it through the slave modport.
interface id_decode_stage_if;
    logic [31:0] pc_out;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic [31:0] imm_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3_out;
    logic        funct7b5_out;
    logic        reg_write_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        mem_to_reg_out;
    logic        alu_src_out;
    logic        branch_out;
    logic        jal_out;
    logic        jalr_out;
    logic        lui_out;
    logic        auipc_out;

    modport master (
        output pc_out, rs1_data_out, rs2_data_out, imm_out,
        output rs1_out, rs2_out, rd_out, funct3_out, funct7b5_out,
        output reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out,
        output alu_src_out, branch_out, jal_out, jalr_out, lui_out, auipc_out
    );

    modport slave (
        input pc_out, rs1_data_out, rs2_data_out, imm_out,
        input rs1_out, rs2_out, rd_out, funct3_out, funct7b5_out,
        input reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out,
        input alu_src_out, branch_out, jal_out, jalr_out, lui_out, auipc_out
    );
endinterface

// File: rtl/id_decode_stage.sv
// RV32I instruction-decode stage: register file, immediate/control decode,
// load-use hazard detection and the ID/EX pipeline register.
// Optional macro DECODE_RF_BYPASS_EN: when defined, a writeback to the register
// being read in the same cycle is forwarded into the operand (write-then-read);
// when undefined, the operand reflects the old register-file contents.
module id_decode_stage #(
    parameter logic [31:0] RESET_PC_VAL = 32'h0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               instr_in,
    input  logic [31:0]               pc_in,
    input  logic                      flush_in,
    input  logic                      wb_we,
    input  logic [4:0]                wb_rd,
    input  logic [31:0]               wb_data,
    output logic                      stall_out,
    id_decode_stage_if.master         idex
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        auipc;
    } idex_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] rf_q [32];
    idex_t       idex_q;
    idex_t       idex_d;
    idex_t       dec;
    idex_t       bubble;

    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic        raw_hazard;

    assign rs1_idx = instr_in[19:15];
    assign rs2_idx = instr_in[24:20];

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

    // Register file: every entry clears on reset; x0 is never written so it stays 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // Operand read; x0 is hard-wired to zero in both bypass modes.
    always_comb begin
`ifdef DECODE_RF_BYPASS_EN
        if (rs1_idx == 5'd0)                     rs1_val = 32'h0;
        else if (wb_we && (wb_rd == rs1_idx))    rs1_val = wb_data;
        else                                     rs1_val = rf_q[rs1_idx];
        if (rs2_idx == 5'd0)                     rs2_val = 32'h0;
        else if (wb_we && (wb_rd == rs2_idx))    rs2_val = wb_data;
        else                                     rs2_val = rf_q[rs2_idx];
`else
        rs1_val = (rs1_idx == 5'd0) ? 32'h0 : rf_q[rs1_idx];
        rs2_val = (rs2_idx == 5'd0) ? 32'h0 : rf_q[rs2_idx];
`endif
    end

    // Opcode decode into the next ID/EX contents; unknown opcodes decode as a bubble.
    always_comb begin
        dec          = '0;
        dec.pc       = pc_in;
        dec.rs1_data = rs1_val;
        dec.rs2_data = rs2_val;
        dec.rs1      = rs1_idx;
        dec.rs2      = rs2_idx;
        dec.funct3   = instr_in[14:12];
        dec.funct7b5 = instr_in[30];
        unique case (instr_in[6:0])
            OP_LUI:    begin dec.imm = imm_u; dec.reg_write = 1'b1; dec.lui   = 1'b1; end
            OP_AUIPC:  begin dec.imm = imm_u; dec.reg_write = 1'b1; dec.auipc = 1'b1; end
            OP_JAL:    begin dec.imm = imm_j; dec.reg_write = 1'b1; dec.jal   = 1'b1; end
            OP_JALR:   begin
                dec.imm = imm_i; dec.reg_write = 1'b1; dec.jalr = 1'b1; dec.alu_src = 1'b1;
            end
            OP_BRANCH: begin dec.imm = imm_b; dec.branch = 1'b1; end
            OP_LOAD:   begin
                dec.imm = imm_i; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
                dec.mem_to_reg = 1'b1; dec.alu_src = 1'b1;
            end
            OP_STORE:  begin dec.imm = imm_s; dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
            OP_IMM:    begin dec.imm = imm_i; dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
            OP_REG:    begin dec.imm = 32'h0; dec.reg_write = 1'b1; end
            default:   begin dec.imm = 32'h0; end
        endcase
        // Forwarding logic relies on rd==0 meaning "no write".
        dec.rd = dec.reg_write ? instr_in[11:7] : 5'd0;
    end

    // Load-use hazard against the load currently in ID/EX; a redirect always wins over the hold.
    always_comb begin
        raw_hazard = idex_q.mem_read && (idex_q.rd != 5'd0) &&
                     ((idex_q.rd == rs1_idx) || (idex_q.rd == rs2_idx));
        stall_out  = raw_hazard && !flush_in;
    end

    // Next ID/EX contents: flush and stall both inject the same bubble.
    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC_VAL;
        idex_d    = (flush_in || stall_out) ? bubble : dec;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= bubble;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idex.pc_out         = idex_q.pc;
    assign idex.rs1_data_out   = idex_q.rs1_data;
    assign idex.rs2_data_out   = idex_q.rs2_data;
    assign idex.imm_out        = idex_q.imm;
    assign idex.rs1_out        = idex_q.rs1;
    assign idex.rs2_out        = idex_q.rs2;
    assign idex.rd_out         = idex_q.rd;
    assign idex.funct3_out     = idex_q.funct3;
    assign idex.funct7b5_out   = idex_q.funct7b5;
    assign idex.reg_write_out  = idex_q.reg_write;
    assign idex.mem_read_out   = idex_q.mem_read;
    assign idex.mem_write_out  = idex_q.mem_write;
    assign idex.mem_to_reg_out = idex_q.mem_to_reg;
    assign idex.alu_src_out    = idex_q.alu_src;
    assign idex.branch_out     = idex_q.branch;
    assign idex.jal_out        = idex_q.jal;
    assign idex.jalr_out       = idex_q.jalr;
    assign idex.lui_out        = idex_q.lui;
    assign idex.auipc_out      = idex_q.auipc;

endmodule
